// File: rtl/miner_pkg.sv
// Shared miner datapath definitions: collector FSM encoding and datapath widths.
package miner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NONCE_W   = 32;
  localparam int HASHCNT_W = 48;

endpackage

// File: rtl/nonce_fifo.sv
// First-word-fall-through FIFO for winning nonces; head is held in a register
// so a write into an empty FIFO is visible on dout the following cycle.
module nonce_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  rd_next;
  logic         empty;
  logic         pop_eff;
  logic         push_eff;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign valid    = ~empty;
  assign pop_eff  = pop & ~empty & ~clear;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_eff = push & ~clear & (~full | pop_eff);
  assign rd_next  = rd_ptr + (AW + 1)'(pop_eff);

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      // New head comes from the incoming word when it lands in the head slot,
      // otherwise from memory after a pop; an empty FIFO keeps the old value.
      if (push_eff && (rd_next == wr_ptr)) begin
        dout <= din;
      end else if (pop_eff && (rd_next != wr_ptr)) begin
        dout <= mem[rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/nonce_collect.sv
// Work-unit nonce collector: FSM, hit qualification, overflow/drop accounting.
// Optional hash counter output enabled by NONCE_COLLECT_HASHCNT_EN.
module nonce_collect
  import miner_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAIL   = 4,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    scan_done,
  input  logic                    found,
  input  logic                    busy,
  input  logic [NONCE_W-1:0]      nonce,
  output logic                    out_valid,
  output logic [NONCE_W-1:0]      out_nonce,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt,
`ifdef NONCE_COLLECT_HASHCNT_EN
  output logic [HASHCNT_W-1:0]    hash_cnt,
`endif
  output logic                    done
);

  localparam int TW = (TAIL > 1) ? $clog2(TAIL) : 1;

  state_t        state;
  logic [TW-1:0] tail_cnt;
  logic          live;
  logic          hit;
  logic          pop;
  logic          full;
  logic          drop;

  assign live = (state == COLLECT) || (state == FLUSH);
  assign hit  = live & found & busy;
  assign pop  = out_valid & out_ready;
  assign drop = hit & full & ~pop;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .W     (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (hit),
    .din   (nonce),
    .pop   (pop),
    .dout  (out_nonce),
    .valid (out_valid),
    .full  (full),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tail_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      state    <= IDLE;
      tail_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (scan_done) begin
            state    <= FLUSH;
            tail_cnt <= TW'(TAIL - 1);
          end
        end
        FLUSH: begin
          // Keep accepting for TAIL cycles so in-flight hashes drain.
          if (tail_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            tail_cnt <= tail_cnt - 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= COLLECT;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

`ifdef NONCE_COLLECT_HASHCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_cnt <= '0;
    end else if (clear) begin
      hash_cnt <= '0;
    end else if (live && busy) begin
      hash_cnt <= hash_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_collect.sv
// Self-checking bench for nonce_collect: a nonce scoreboard queue plus expected
// overflow/drop state, compared every cycle at the falling edge.
module tb_nonce_collect;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic        scan_done;
  logic        found;
  logic        busy;
  logic [31:0] nonce;
  logic        out_valid;
  logic [31:0] out_nonce;
  logic        out_ready;
  logic [3:0]  fifo_cnt;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        done;
`ifdef NONCE_COLLECT_HASHCNT_EN
  logic [47:0] hash_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          exp_drop = 0;
  logic        exp_ovf = 1'b0;

  nonce_collect #(
    .DEPTH  (DEPTH),
    .TAIL   (4),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .start     (start),
    .scan_done (scan_done),
    .found     (found),
    .busy      (busy),
    .nonce     (nonce),
    .out_valid (out_valid),
    .out_nonce (out_nonce),
    .out_ready (out_ready),
    .fifo_cnt  (fifo_cnt),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
`ifdef NONCE_COLLECT_HASHCNT_EN
    .hash_cnt  (hash_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // One clock cycle: drive inputs, check outputs at the falling edge, update the
  // scoreboard with what this cycle's edge should do. 'live' = state COLLECT/FLUSH.
  task automatic cycle(input logic f, input logic b, input logic [31:0] n,
                       input logic rdy, input logic live);
    logic [31:0] e;
    found = f; busy = b; nonce = n; out_ready = rdy;
    @(negedge clk);
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
    end
    checks++;
    if (fifo_cnt !== 4'(exp_q.size())) begin
      errors++;
      $display("FAIL fifo_cnt: got %0d expected %0d", fifo_cnt, exp_q.size());
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow: got %b expected %b", overflow, exp_ovf);
    end
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, exp_drop);
    end
    if (clear) begin
      exp_q.delete();
      exp_drop = 0;
      exp_ovf  = 1'b0;
    end else begin
      if (rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_nonce !== e) begin
          errors++;
          $display("FAIL out_nonce: got %h expected %h", out_nonce, e);
        end else begin
          $display("pop nonce=%h", out_nonce);
        end
      end
      if (live && f && b) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(n);
        end else begin
          exp_ovf = 1'b1;
          if (exp_drop < 255) exp_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0; scan_done = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; start = 1'b0; scan_done = 1'b0;
    found = 1'b0; busy = 1'b0; nonce = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_nonce, fifo_cnt, overflow, drop_cnt, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b n=%h c=%0d o=%b d=%0d done=%b expected all zero",
               out_valid, out_nonce, fifo_cnt, overflow, drop_cnt, done);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    start = 1'b1;
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 32'h11, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 32'h22, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 32'h33, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 32'h44, 1, 1);  // found without busy is not a hit
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (fifo_cnt !== 4'd0) begin
      errors++;
      $display("FAIL basic_drain: got fifo_cnt %0d expected 0", fifo_cnt);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) cycle(1, 1, 32'h100 + 32'(i), 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (fifo_cnt !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overflow_fill: got cnt=%0d ovf=%b drops=%0d expected cnt=8 ovf=1 drops=2",
               fifo_cnt, overflow, drop_cnt);
    end
    cycle(1, 1, 32'hAA, 1, 1);  // full + pop + hit
    checks++;
    if (fifo_cnt !== 4'd8 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL full_pop_hit: got cnt=%0d drops=%0d expected cnt=8 drops=2",
               fifo_cnt, drop_cnt);
    end
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 1);
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 308; i++) cycle(1, 1, 32'h1000 + 32'(i), 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
    end
    clear = 1'b1;
    cycle(1, 1, 32'hBB, 1, 1);
    checks++;
    if ({out_valid, fifo_cnt, overflow, drop_cnt, done} !== '0) begin
      errors++;
      $display("FAIL clear_state: got v=%b c=%0d o=%b d=%0d done=%b expected all zero",
               out_valid, fifo_cnt, overflow, drop_cnt, done);
    end
    cycle(1, 1, 32'h77, 0, 0);  // IDLE after clear: hit ignored
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_tail();
    start = 1'b1;
    cycle(0, 0, 0, 1, 0);
    scan_done = 1'b1;
    cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 32'h55, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL tail_early: got done=%b expected 0 three cycles after scan_done", done);
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL tail_done: got done=%b expected 1 four cycles after scan_done", done);
    end
    cycle(1, 1, 32'h66, 1, 0);  // first DONE cycle: ignored, not a drop
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_flush();
    start = 1'b1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 32'hA1, 0, 1);
    cycle(1, 1, 32'hA2, 0, 1);
    cycle(1, 1, 32'hA3, 0, 1);
    scan_done = 1'b1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_nonce, fifo_cnt, overflow, drop_cnt, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b n=%h c=%0d o=%b d=%0d done=%b expected all zero",
               out_valid, out_nonce, fifo_cnt, overflow, drop_cnt, done);
    end
    exp_q.delete();
    exp_drop = 0;
    exp_ovf  = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hashcnt();
`ifdef NONCE_COLLECT_HASHCNT_EN
    checks++;
    if (hash_cnt !== 48'd0) begin
      errors++;
      $display("FAIL hash_cnt_reset: got %0d expected 0", hash_cnt);
    end
`endif
    start = 1'b1;
    cycle(0, 1, 0, 0, 0);  // busy in IDLE is not counted
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1);
`ifdef NONCE_COLLECT_HASHCNT_EN
    checks++;
    if (hash_cnt !== 48'd5) begin
      errors++;
      $display("FAIL hash_cnt: got %0d expected 5", hash_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_saturate_clear();
    test_tail();
    test_reset_mid_flush();
    test_hashcnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
